id_ex_fwd_reg: RTL and testbench

- ID/EX pipeline register sitting directly upstream of the EX-stage operand forwarding muxes.
- Captures decoded operands, register addresses and control from ID.
- Precomputes the 2-bit forwarding selects for rs and rt one cycle early and registers them alongside the operands, so EX has no address comparators on its critical path.
- Detects load-use hazards internally, inserts a bubble and requests an upstream stall.

---
 rtl/id_ex_fwd_reg_pkg.sv | 22 ++
 rtl/id_ex_fwd_reg_if.sv | 67 ++++++
 rtl/id_ex_fwd_reg_fwd_sel_calc.sv | 25 ++
 rtl/id_ex_fwd_reg.sv | 123 ++++++++++++
 tb/tb_id_ex_fwd_reg.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_fwd_reg_pkg.sv
// Shared CPU pipeline types: datapath widths, forwarding-select encodings
// and the decoded control bundle carried from ID into EX.
package cpu_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int ALUC_W = 4;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

   typedef struct packed {
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              mem_to_reg;
      logic              alu_src;
      logic [ALUC_W-1:0] aluc;
   } ctrl_t;

endpackage

// File: rtl/id_ex_fwd_reg_if.sv
// ID-side inputs, MEM-stage producer info and EX-side outputs of the
// ID/EX register; master is the surrounding pipeline, slave the register.
interface id_ex_fwd_reg_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int ALUC_W = 4
);
   import cpu_pkg::*;

   logic              hold_i;
   logic              flush_i;
   logic              id_valid_i;
   logic [REG_AW-1:0] id_rs_i;
   logic [REG_AW-1:0] id_rt_i;
   logic [REG_AW-1:0] id_rd_i;
   logic              id_rs_used_i;
   logic              id_rt_used_i;
   logic [DATA_W-1:0] id_rs_data_i;
   logic [DATA_W-1:0] id_rt_data_i;
   logic [DATA_W-1:0] id_imm_i;
   logic [ALUC_W-1:0] id_aluc_i;
   logic              id_reg_write_i;
   logic              id_mem_read_i;
   logic              id_mem_write_i;
   logic              id_mem_to_reg_i;
   logic              id_alu_src_i;
   logic [REG_AW-1:0] mem_rd_i;
   logic              mem_reg_write_i;

   logic              stall_o;
   logic              ex_valid_o;
   logic [REG_AW-1:0] ex_rs_o;
   logic [REG_AW-1:0] ex_rt_o;
   logic [REG_AW-1:0] ex_rd_o;
   logic [DATA_W-1:0] ex_rs_data_o;
   logic [DATA_W-1:0] ex_rt_data_o;
   logic [DATA_W-1:0] ex_imm_o;
   logic [ALUC_W-1:0] ex_aluc_o;
   logic              ex_reg_write_o;
   logic              ex_mem_read_o;
   logic              ex_mem_write_o;
   logic              ex_mem_to_reg_o;
   logic              ex_alu_src_o;
   logic [1:0]        ex_fwd_a_o;
   logic [1:0]        ex_fwd_b_o;

   modport master (
      output hold_i, flush_i, id_valid_i, id_rs_i, id_rt_i, id_rd_i,
             id_rs_used_i, id_rt_used_i, id_rs_data_i, id_rt_data_i, id_imm_i,
             id_aluc_i, id_reg_write_i, id_mem_read_i, id_mem_write_i,
             id_mem_to_reg_i, id_alu_src_i, mem_rd_i, mem_reg_write_i,
      input  stall_o, ex_valid_o, ex_rs_o, ex_rt_o, ex_rd_o, ex_rs_data_o,
             ex_rt_data_o, ex_imm_o, ex_aluc_o, ex_reg_write_o, ex_mem_read_o,
             ex_mem_write_o, ex_mem_to_reg_o, ex_alu_src_o, ex_fwd_a_o, ex_fwd_b_o
   );

   modport slave (
      input  hold_i, flush_i, id_valid_i, id_rs_i, id_rt_i, id_rd_i,
             id_rs_used_i, id_rt_used_i, id_rs_data_i, id_rt_data_i, id_imm_i,
             id_aluc_i, id_reg_write_i, id_mem_read_i, id_mem_write_i,
             id_mem_to_reg_i, id_alu_src_i, mem_rd_i, mem_reg_write_i,
      output stall_o, ex_valid_o, ex_rs_o, ex_rt_o, ex_rd_o, ex_rs_data_o,
             ex_rt_data_o, ex_imm_o, ex_aluc_o, ex_reg_write_o, ex_mem_read_o,
             ex_mem_write_o, ex_mem_to_reg_o, ex_alu_src_o, ex_fwd_a_o, ex_fwd_b_o
   );

endinterface

// File: rtl/id_ex_fwd_reg_fwd_sel_calc.sv
// Next forwarding select for one ID source register, based on which
// downstream stage will hold its most recent producer one cycle from now.
module fwd_sel_calc #(
   parameter int REG_AW = 5
) (
   input  logic              ex_valid,
   input  logic              ex_reg_write,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [REG_AW-1:0] id_reg,
   output logic [1:0]        sel
);
   import cpu_pkg::*;

   // The EX producer is younger than the MEM one, so it is tested first.
   always_comb begin
      sel = FWD_REG;
      if (ex_valid && ex_reg_write && (ex_rd != '0) && (ex_rd == id_reg))
         sel = FWD_EXMEM;
      else if (mem_reg_write && (mem_rd != '0) && (mem_rd == id_reg))
         sel = FWD_MEMWB;
   end

endmodule

// File: rtl/id_ex_fwd_reg.sv
// ID/EX pipeline register with registered forwarding selects and internal
// load-use detection (bubble insertion plus upstream stall request).
module id_ex_fwd_reg #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int ALUC_W = 4
) (
   input logic           clk_i,
   input logic           rst_i,
   id_ex_fwd_reg_if.slave bus
);
   import cpu_pkg::*;

   logic              vld_p0, vld_p1;
   ctrl_t             ctrl_p0, ctrl_p1;
   logic [REG_AW-1:0] rs_p0, rs_p1, rt_p0, rt_p1, rd_p0, rd_p1;
   logic [DATA_W-1:0] rs_data_p0, rs_data_p1, rt_data_p0, rt_data_p1;
   logic [DATA_W-1:0] imm_p0, imm_p1;
   logic [1:0]        fwd_a_p0, fwd_a_p1, fwd_b_p0, fwd_b_p1;
   logic [1:0]        fwd_a_nxt, fwd_b_nxt;
   logic              load_use;

   assign load_use = vld_p1 && ctrl_p1.mem_read && (rd_p1 != '0) && bus.id_valid_i &&
                     ((bus.id_rs_used_i && (bus.id_rs_i == rd_p1)) ||
                      (bus.id_rt_used_i && (bus.id_rt_i == rd_p1)));

   assign bus.stall_o = load_use && !bus.flush_i && !bus.hold_i;

   fwd_sel_calc #(.REG_AW(REG_AW)) u_fwd_a (
      .ex_valid      (vld_p1),
      .ex_reg_write  (ctrl_p1.reg_write),
      .ex_rd         (rd_p1),
      .mem_reg_write (bus.mem_reg_write_i),
      .mem_rd        (bus.mem_rd_i),
      .id_reg        (bus.id_rs_i),
      .sel           (fwd_a_nxt)
   );

   fwd_sel_calc #(.REG_AW(REG_AW)) u_fwd_b (
      .ex_valid      (vld_p1),
      .ex_reg_write  (ctrl_p1.reg_write),
      .ex_rd         (rd_p1),
      .mem_reg_write (bus.mem_reg_write_i),
      .mem_rd        (bus.mem_rd_i),
      .id_reg        (bus.id_rt_i),
      .sel           (fwd_b_nxt)
   );

   // ID stage: bubble by default, capture when neither flushed nor load-use blocked
   always_comb begin
      vld_p0     = 1'b0;
      ctrl_p0    = '0;
      rs_p0      = '0;
      rt_p0      = '0;
      rd_p0      = '0;
      rs_data_p0 = '0;
      rt_data_p0 = '0;
      imm_p0     = '0;
      fwd_a_p0   = FWD_REG;
      fwd_b_p0   = FWD_REG;
      if (!(bus.flush_i || load_use)) begin
         vld_p0             = bus.id_valid_i;
         ctrl_p0.reg_write  = bus.id_reg_write_i  && bus.id_valid_i;
         ctrl_p0.mem_read   = bus.id_mem_read_i   && bus.id_valid_i;
         ctrl_p0.mem_write  = bus.id_mem_write_i  && bus.id_valid_i;
         ctrl_p0.mem_to_reg = bus.id_mem_to_reg_i && bus.id_valid_i;
         ctrl_p0.alu_src    = bus.id_alu_src_i;
         ctrl_p0.aluc       = bus.id_aluc_i;
         rs_p0              = bus.id_rs_i;
         rt_p0              = bus.id_rt_i;
         rd_p0              = bus.id_rd_i;
         rs_data_p0         = bus.id_rs_data_i;
         rt_data_p0         = bus.id_rt_data_i;
         imm_p0             = bus.id_imm_i;
         fwd_a_p0           = fwd_a_nxt;
         fwd_b_p0           = fwd_b_nxt;
      end
   end

   // EX stage: frozen as a whole while hold_i is asserted
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         vld_p1     <= 1'b0;
         ctrl_p1    <= '0;
         rs_p1      <= '0;
         rt_p1      <= '0;
         rd_p1      <= '0;
         rs_data_p1 <= '0;
         rt_data_p1 <= '0;
         imm_p1     <= '0;
         fwd_a_p1   <= FWD_REG;
         fwd_b_p1   <= FWD_REG;
      end else if (!bus.hold_i) begin
         vld_p1     <= vld_p0;
         ctrl_p1    <= ctrl_p0;
         rs_p1      <= rs_p0;
         rt_p1      <= rt_p0;
         rd_p1      <= rd_p0;
         rs_data_p1 <= rs_data_p0;
         rt_data_p1 <= rt_data_p0;
         imm_p1     <= imm_p0;
         fwd_a_p1   <= fwd_a_p0;
         fwd_b_p1   <= fwd_b_p0;
      end
   end

   assign bus.ex_valid_o      = vld_p1;
   assign bus.ex_rs_o         = rs_p1;
   assign bus.ex_rt_o         = rt_p1;
   assign bus.ex_rd_o         = rd_p1;
   assign bus.ex_rs_data_o    = rs_data_p1;
   assign bus.ex_rt_data_o    = rt_data_p1;
   assign bus.ex_imm_o        = imm_p1;
   assign bus.ex_aluc_o       = ALUC_W'(ctrl_p1.aluc);
   assign bus.ex_reg_write_o  = ctrl_p1.reg_write;
   assign bus.ex_mem_read_o   = ctrl_p1.mem_read;
   assign bus.ex_mem_write_o  = ctrl_p1.mem_write;
   assign bus.ex_mem_to_reg_o = ctrl_p1.mem_to_reg;
   assign bus.ex_alu_src_o    = ctrl_p1.alu_src;
   assign bus.ex_fwd_a_o      = fwd_a_p1;
   assign bus.ex_fwd_b_o      = fwd_b_p1;

endmodule

// File: tb/tb_id_ex_fwd_reg.sv
// Bench for id_ex_fwd_reg: directed vector table, async-reset sequence and
// randomized traffic against a stage-level pipeline model.
module tb_id_ex_fwd_reg;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   id_ex_fwd_reg_if #(.DATA_W(32), .REG_AW(5), .ALUC_W(4)) bus ();

   id_ex_fwd_reg #(.DATA_W(32), .REG_AW(5), .ALUC_W(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        hold, flush, v;
      logic [4:0]  rs, rt, rd;
      logic        rsu, rtu, rw, mr, mw, m2r, as;
      logic [3:0]  aluc;
      logic [31:0] rsd, rtd, imm;
      logic [4:0]  mrd;
      logic        mrw;
   } in_t;

   typedef struct {
      in_t         i;
      logic        stall, vld, mr;
      logic [4:0]  rd;
      logic [1:0]  fa, fb;
   } vec_t;

   // Expected EX-side contents; dk/ck/sk mark which fields are defined.
   typedef struct {
      logic        vld, rw, mr, mw, m2r, as;
      logic [3:0]  aluc;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rsd, rtd, imm;
      logic [1:0]  fa, fb;
      logic        dk, ck, sk;
   } st_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input in_t x);
      bus.hold_i          = x.hold;
      bus.flush_i         = x.flush;
      bus.id_valid_i      = x.v;
      bus.id_rs_i         = x.rs;
      bus.id_rt_i         = x.rt;
      bus.id_rd_i         = x.rd;
      bus.id_rs_used_i    = x.rsu;
      bus.id_rt_used_i    = x.rtu;
      bus.id_rs_data_i    = x.rsd;
      bus.id_rt_data_i    = x.rtd;
      bus.id_imm_i        = x.imm;
      bus.id_aluc_i       = x.aluc;
      bus.id_reg_write_i  = x.rw;
      bus.id_mem_read_i   = x.mr;
      bus.id_mem_write_i  = x.mw;
      bus.id_mem_to_reg_i = x.m2r;
      bus.id_alu_src_i    = x.as;
      bus.mem_rd_i        = x.mrd;
      bus.mem_reg_write_i = x.mrw;
   endtask

   function automatic vec_t mk(input logic h, f, v, input int rs, rt, rd,
                               input logic rsu, rtu, rw, mr, input int mrd, input logic mrw,
                               input logic es, ev, emr, input int erd, efa, efb);
      vec_t t;
      t.i.hold = h; t.i.flush = f; t.i.v = v;
      t.i.rs = 5'(rs); t.i.rt = 5'(rt); t.i.rd = 5'(rd);
      t.i.rsu = rsu; t.i.rtu = rtu; t.i.rw = rw; t.i.mr = mr;
      t.i.mw = 1'b0; t.i.m2r = mr; t.i.as = mr; t.i.aluc = 4'(rd);
      t.i.rsd = '0; t.i.rtd = '0; t.i.imm = '0;
      t.i.mrd = 5'(mrd); t.i.mrw = mrw;
      t.stall = es; t.vld = ev; t.mr = emr; t.rd = 5'(erd);
      t.fa = 2'(efa); t.fb = 2'(efb);
      return t;
   endfunction

   // Which later stage will hold the youngest writer of r: 2 = EX/MEM, 1 = MEM/WB.
   function automatic logic [1:0] src_of(input st_t ex, input logic [4:0] r,
                                         input logic [4:0] mrd, input logic mrw);
      if (r == 0) return 2'd0;
      if (ex.vld && ex.rw && ex.rd == r) return 2'd2;
      if (mrw && mrd == r) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic lu_of(input st_t ex, input in_t x);
      logic reads_it;
      reads_it = (x.rsu && x.rs == ex.rd) || (x.rtu && x.rt == ex.rd);
      return ex.vld && ex.mr && ex.rd != 0 && x.v && reads_it;
   endfunction

   function automatic st_t zero_st(input logic known);
      st_t s;
      s = '{default: '0};
      s.dk = known; s.ck = known; s.sk = 1'b1;
      return s;
   endfunction

   function automatic st_t next_st(input st_t m, input in_t x);
      st_t n;
      if (x.hold) return m;
      if (x.flush || lu_of(m, x)) return zero_st(1'b0);
      n.vld = x.v; n.rw = x.v & x.rw; n.mr = x.v & x.mr;
      n.mw = x.v & x.mw; n.m2r = x.v & x.m2r; n.as = x.as; n.aluc = x.aluc;
      n.rs = x.rs; n.rt = x.rt; n.rd = x.rd;
      n.rsd = x.rsd; n.rtd = x.rtd; n.imm = x.imm;
      n.fa = src_of(m, x.rs, x.mrd, x.mrw);
      n.fb = src_of(m, x.rt, x.mrd, x.mrw);
      n.dk = 1'b1; n.ck = x.v; n.sk = x.v;
      return n;
   endfunction

   task automatic check_state(input string tag, input st_t e);
      chk({tag, " valid"},      32'(bus.ex_valid_o),      32'(e.vld));
      chk({tag, " reg_write"},  32'(bus.ex_reg_write_o),  32'(e.rw));
      chk({tag, " mem_read"},   32'(bus.ex_mem_read_o),   32'(e.mr));
      chk({tag, " mem_write"},  32'(bus.ex_mem_write_o),  32'(e.mw));
      chk({tag, " mem_to_reg"}, 32'(bus.ex_mem_to_reg_o), 32'(e.m2r));
      if (e.dk) begin
         chk({tag, " rs"},      32'(bus.ex_rs_o),  32'(e.rs));
         chk({tag, " rt"},      32'(bus.ex_rt_o),  32'(e.rt));
         chk({tag, " rd"},      32'(bus.ex_rd_o),  32'(e.rd));
         chk({tag, " rs_data"}, bus.ex_rs_data_o,  e.rsd);
         chk({tag, " rt_data"}, bus.ex_rt_data_o,  e.rtd);
         chk({tag, " imm"},     bus.ex_imm_o,      e.imm);
      end
      if (e.ck) begin
         chk({tag, " alu_src"}, 32'(bus.ex_alu_src_o), 32'(e.as));
         chk({tag, " aluc"},    32'(bus.ex_aluc_o),    32'(e.aluc));
      end
      if (e.sk) begin
         chk({tag, " fwd_a"}, 32'(bus.ex_fwd_a_o), 32'(e.fa));
         chk({tag, " fwd_b"}, 32'(bus.ex_fwd_b_o), 32'(e.fb));
      end
   endtask

   function automatic in_t rnd_in();
      in_t x;
      x.hold = ($urandom_range(0, 9) == 0);
      x.flush = ($urandom_range(0, 9) == 0);
      x.v = ($urandom_range(0, 4) != 0);
      x.rs = 5'($urandom_range(0, 3)); x.rt = 5'($urandom_range(0, 3));
      x.rd = 5'($urandom_range(0, 3));
      x.rsu = 1'($urandom); x.rtu = 1'($urandom); x.rw = 1'($urandom);
      x.mr = 1'($urandom); x.mw = 1'($urandom); x.m2r = 1'($urandom);
      x.as = 1'($urandom); x.aluc = 4'($urandom);
      x.rsd = $urandom; x.rtd = $urandom; x.imm = $urandom;
      x.mrd = 5'($urandom_range(0, 3)); x.mrw = 1'($urandom);
      return x;
   endfunction

   vec_t vt[21];
   logic [31:0] last_rsd;
   st_t m;
   in_t x;

   initial begin
      //          h f v rs rt rd rsu rtu rw mr mrd mrw | stall vld mr rd fa fb
      vt[0]  = mk(0,0,1, 1, 2, 3, 1,1,1,0,  0,0, 0,1,0, 3,0,0);
      vt[1]  = mk(0,0,1, 3, 5, 4, 1,1,1,0,  0,0, 0,1,0, 4,2,0);
      vt[2]  = mk(0,0,1, 1, 2, 9, 1,1,1,0,  0,0, 0,1,0, 9,0,0);
      vt[3]  = mk(0,0,1, 1, 7,10, 1,1,1,0,  7,1, 0,1,0,10,0,1);
      vt[4]  = mk(0,0,1, 1,10,11, 1,1,1,0, 10,1, 0,1,0,11,0,2);
      vt[5]  = mk(1,0,1,11,11,20, 1,1,1,1, 11,1, 0,1,0,11,0,2);
      vt[6]  = mk(0,0,1, 1, 0, 8, 1,0,1,1,  0,0, 0,1,1, 8,0,0);
      vt[7]  = mk(0,0,1, 8, 2,12, 1,1,1,0,  0,0, 1,0,0, 0,0,0);
      vt[8]  = mk(0,0,1, 8, 2,12, 1,1,1,0,  8,1, 0,1,0,12,1,0);
      vt[9]  = mk(0,0,1, 1, 2, 0, 1,1,1,1,  0,0, 0,1,1, 0,0,0);
      vt[10] = mk(0,0,1, 0, 0,13, 1,1,1,0,  0,0, 0,1,0,13,0,0);
      vt[11] = mk(0,1,1,13,13,14, 1,1,1,0,  0,0, 0,0,0, 0,0,0);
      vt[12] = mk(0,0,1, 1, 2, 6, 1,1,1,1,  0,0, 0,1,1, 6,0,0);
      vt[13] = mk(1,1,1, 6, 2,15, 1,1,1,0,  0,0, 0,1,1, 6,0,0);
      vt[14] = mk(1,0,1, 6, 2,15, 1,1,1,0,  0,0, 0,1,1, 6,0,0);
      vt[15] = mk(0,1,1, 6, 2,15, 1,1,1,0,  0,0, 0,0,0, 0,0,0);
      vt[16] = mk(0,0,0, 3, 2,16, 1,1,1,1,  0,0, 0,0,0, 0,0,0);
      vt[17] = mk(0,0,1, 1, 2, 5, 1,1,1,1,  0,0, 0,1,1, 5,0,0);
      vt[18] = mk(0,0,1, 1, 5,17, 1,0,1,0,  0,0, 0,1,0,17,0,2);
      vt[19] = mk(0,0,1, 1, 2, 5, 1,1,1,1,  0,0, 0,1,1, 5,0,0);
      vt[20] = mk(0,0,1, 2, 5,18, 1,1,1,0,  0,0, 1,0,0, 0,0,0);
      for (int k = 0; k < 21; k++) begin
         vt[k].i.rsd = 32'hA000_0000 + 32'(k);
         vt[k].i.rtd = 32'hB000_0000 + 32'(k);
         vt[k].i.imm = 32'hC000_0000 + 32'(k);
      end

      apply(vt[0].i);
      bus.flush_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_state("reset", zero_st(1'b1));
      chk("reset stall", 32'(bus.stall_o), 32'd0);
      rst = 1'b1;

      last_rsd = '0;
      for (int k = 0; k < 21; k++) begin
         apply(vt[k].i);
         @(negedge clk);
         chk($sformatf("v%0d stall", k), 32'(bus.stall_o), 32'(vt[k].stall));
         @(posedge clk);
         #1;
         if (!vt[k].i.hold && vt[k].vld) last_rsd = vt[k].i.rsd;
         chk($sformatf("v%0d valid", k),    32'(bus.ex_valid_o),    32'(vt[k].vld));
         chk($sformatf("v%0d mem_read", k), 32'(bus.ex_mem_read_o), 32'(vt[k].mr));
         chk($sformatf("v%0d fwd_a", k),    32'(bus.ex_fwd_a_o),    32'(vt[k].fa));
         chk($sformatf("v%0d fwd_b", k),    32'(bus.ex_fwd_b_o),    32'(vt[k].fb));
         if (vt[k].vld) begin
            chk($sformatf("v%0d rd", k),      32'(bus.ex_rd_o), 32'(vt[k].rd));
            chk($sformatf("v%0d rs_data", k), bus.ex_rs_data_o, last_rsd);
         end
      end

      // Async reset while every output is nonzero, then a normal first capture.
      x = rnd_in();
      x.hold = 0; x.flush = 0; x.v = 1; x.rs = 5'd1; x.rt = 5'd2; x.rd = 5'd21;
      x.rw = 1; x.mr = 0; x.mrw = 0;
      apply(x);
      @(posedge clk); #1;
      x.rs = 5'd21; x.rt = 5'd21; x.rd = 5'd22; x.rsu = 0; x.rtu = 0;
      x.rw = 1; x.mr = 1; x.mw = 1; x.m2r = 1; x.as = 1; x.aluc = 4'hF;
      x.rsd = 32'hFFFF_0001; x.rtd = 32'hFFFF_0002; x.imm = 32'hFFFF_0003;
      apply(x);
      @(posedge clk); #1;
      chk("pre-reset fwd_a", 32'(bus.ex_fwd_a_o), 32'd2);
      chk("pre-reset valid", 32'(bus.ex_valid_o), 32'd1);
      x.rs = 5'd22; x.rsu = 1; x.rd = 5'd23; x.mr = 0;
      apply(x);
      #2;
      rst = 1'b0;
      #1;
      check_state("async reset", zero_st(1'b1));
      chk("async reset stall", 32'(bus.stall_o), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("post-reset stall", 32'(bus.stall_o), 32'd0);
      @(posedge clk); #1;
      chk("post-reset valid", 32'(bus.ex_valid_o), 32'd1);
      chk("post-reset rd",    32'(bus.ex_rd_o),    32'd23);
      chk("post-reset fwd_a", 32'(bus.ex_fwd_a_o), 32'd0);

      // Randomized traffic against the stage model from a fresh reset.
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      m = zero_st(1'b1);
      for (int c = 0; c < 400; c++) begin
         x = rnd_in();
         apply(x);
         @(negedge clk);
         chk($sformatf("r%0d stall", c), 32'(bus.stall_o),
             32'(lu_of(m, x) && !x.flush && !x.hold));
         m = next_st(m, x);
         @(posedge clk); #1;
         check_state($sformatf("r%0d", c), m);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
